// File: rtl/sprite_layer.sv
// Sprite renderer: maps draw_x/draw_y to a frame-based sprite-ROM address and
// pipelines the palette lookup into gated RGB plus an opaque flag for the
// compositor. Define SPRITE_HFLIP_EN to add the flip port and horizontal mirroring.
module sprite_layer #(
  parameter int SPR_W      = 96,
  parameter int SPR_H      = 112,
  parameter int FRAMES     = 4,
  parameter int ADDR_W     = 16,
  parameter int IDX_W      = 3,
  parameter int TRANSP_IDX = 0,
  parameter int FS_W       = 2
) (
  input  logic              vga_clk,
  input  logic              reset,
  input  logic [9:0]        draw_x,
  input  logic [9:0]        draw_y,
  input  logic              blank,
  input  logic              frame_start,
  input  logic [9:0]        pos_x,
  input  logic [9:0]        pos_y,
  input  logic [FS_W-1:0]   frame_sel,
`ifdef SPRITE_HFLIP_EN
  input  logic              flip,
`endif
  output logic [ADDR_W-1:0] rom_address,
  input  logic [IDX_W-1:0]  rom_q,
  output logic [IDX_W-1:0]  pix_index,
  input  logic [3:0]        pal_red,
  input  logic [3:0]        pal_green,
  input  logic [3:0]        pal_blue,
  output logic [3:0]        red,
  output logic [3:0]        green,
  output logic [3:0]        blue,
  output logic              opaque
);

  localparam logic [10:0]       SPR_W_C    = 11'(SPR_W);
  localparam logic [10:0]       SPR_H_C    = 11'(SPR_H);
  localparam logic [ADDR_W-1:0] ROW_STRIDE = ADDR_W'(SPR_W);
  localparam logic [ADDR_W-1:0] FRAME_SIZE = ADDR_W'(SPR_W * SPR_H);
  localparam logic [IDX_W-1:0]  TRANSP_C   = IDX_W'(TRANSP_IDX);

  // Per-frame latched placement
  logic [9:0]        pos_x_q, pos_x_d;
  logic [9:0]        pos_y_q, pos_y_d;
  logic [ADDR_W-1:0] base_q, base_d;
`ifdef SPRITE_HFLIP_EN
  logic              flip_q, flip_d;
`endif

  // Pixel pipeline
  logic [ADDR_W-1:0] rom_address_q, rom_address_d;
  logic              hit1_q, hit1_d;
  logic [IDX_W-1:0]  pix_index_q, pix_index_d;
  logic              hit2_q, hit2_d;
  logic              opaque_q, opaque_d;
  logic [3:0]        red_q, red_d;
  logic [3:0]        green_q, green_d;
  logic [3:0]        blue_q, blue_d;

  // S0 combinational hit test
  logic [10:0] rel_x;
  logic [10:0] rel_y;
  logic [10:0] col;
  logic        hit;
  logic        frame_ok;

  // NOTE: every signal assigned in always_comb gets a value first; a missing
  // default on any path would infer a latch.
  always_comb begin
    rel_x = {1'b0, draw_x} - {1'b0, pos_x_q};
    rel_y = {1'b0, draw_y} - {1'b0, pos_y_q};
    // The >= terms stop an unsigned wrap from aliasing pixels left/above the sprite.
    hit   = (draw_x >= pos_x_q) && (rel_x < SPR_W_C) &&
            (draw_y >= pos_y_q) && (rel_y < SPR_H_C);
`ifdef SPRITE_HFLIP_EN
    col   = flip_q ? (SPR_W_C - 11'd1 - rel_x) : rel_x;
`else
    col   = rel_x;
`endif
  end

  always_comb begin
    frame_ok = (32'(frame_sel) < 32'(FRAMES));

    pos_x_d = pos_x_q;
    pos_y_d = pos_y_q;
    base_d  = base_q;
`ifdef SPRITE_HFLIP_EN
    flip_d  = flip_q;
`endif
    if (frame_start) begin
      pos_x_d = pos_x;
      pos_y_d = pos_y;
      base_d  = frame_ok ? ADDR_W'(frame_sel) * FRAME_SIZE : '0;
`ifdef SPRITE_HFLIP_EN
      flip_d  = flip;
`endif
    end

    rom_address_d = rom_address_q;
    if (hit) begin
      rom_address_d = base_q + ADDR_W'(rel_y) * ROW_STRIDE + ADDR_W'(col);
    end
    hit1_d = hit & blank;

    pix_index_d = rom_q;
    hit2_d      = hit1_q;

    opaque_d = hit2_q && (pix_index_q != TRANSP_C);
    red_d    = opaque_d ? pal_red   : 4'd0;
    green_d  = opaque_d ? pal_green : 4'd0;
    blue_d   = opaque_d ? pal_blue  : 4'd0;
  end

  // NOTE: state is updated with non-blocking assignments so every flop samples
  // the pre-edge value of its neighbours, independent of statement order.
  always_ff @(posedge vga_clk) begin
    if (reset) begin
      pos_x_q       <= '0;
      pos_y_q       <= '0;
      base_q        <= '0;
`ifdef SPRITE_HFLIP_EN
      flip_q        <= 1'b0;
`endif
      rom_address_q <= '0;
      hit1_q        <= 1'b0;
      pix_index_q   <= '0;
      hit2_q        <= 1'b0;
      opaque_q      <= 1'b0;
      red_q         <= '0;
      green_q       <= '0;
      blue_q        <= '0;
    end else begin
      pos_x_q       <= pos_x_d;
      pos_y_q       <= pos_y_d;
      base_q        <= base_d;
`ifdef SPRITE_HFLIP_EN
      flip_q        <= flip_d;
`endif
      rom_address_q <= rom_address_d;
      hit1_q        <= hit1_d;
      pix_index_q   <= pix_index_d;
      hit2_q        <= hit2_d;
      opaque_q      <= opaque_d;
      red_q         <= red_d;
      green_q       <= green_d;
      blue_q        <= blue_d;
    end
  end

  assign rom_address = rom_address_q;
  assign pix_index   = pix_index_q;
  assign opaque      = opaque_q;
  assign red         = red_q;
  assign green       = green_q;
  assign blue        = blue_q;

endmodule

// File: tb/tb_sprite_layer.sv
// Self-checking bench for sprite_layer: combinational ROM/palette models and a
// scoreboard queue of expected pixels popped three clocks after each drive.
module tb_sprite_layer;

  localparam int W = 96;
  localparam int H = 112;
  localparam int NFRAMES = 3;

  logic        vga_clk;
  logic        reset;
  logic [9:0]  draw_x, draw_y;
  logic        blank, frame_start;
  logic [9:0]  pos_x, pos_y;
  logic [1:0]  frame_sel;
  logic        flip;
  logic [15:0] rom_address;
  logic [2:0]  rom_q, pix_index;
  logic [3:0]  pal_red, pal_green, pal_blue;
  logic [3:0]  red, green, blue;
  logic        opaque;

  sprite_layer #(.FRAMES(NFRAMES), .FS_W(2)) dut (
    .vga_clk     (vga_clk),
    .reset       (reset),
    .draw_x      (draw_x),
    .draw_y      (draw_y),
    .blank       (blank),
    .frame_start (frame_start),
    .pos_x       (pos_x),
    .pos_y       (pos_y),
    .frame_sel   (frame_sel),
`ifdef SPRITE_HFLIP_EN
    .flip        (flip),
`endif
    .rom_address (rom_address),
    .rom_q       (rom_q),
    .pix_index   (pix_index),
    .pal_red     (pal_red),
    .pal_green   (pal_green),
    .pal_blue    (pal_blue),
    .red         (red),
    .green       (green),
    .blue        (blue),
    .opaque      (opaque)
  );

  initial vga_clk = 1'b0;
  always #5 vga_clk = ~vga_clk;

  function automatic logic [2:0] rom_f(input logic [15:0] a);
    return 3'((32'(a) + 5) % 8);
  endfunction

  assign rom_q     = rom_f(rom_address);
  assign pal_red   = {1'b0, pix_index};
  assign pal_green = {1'b0, pix_index} + 4'd3;
  assign pal_blue  = ~{1'b0, pix_index};

  typedef struct {
    logic       opq;
    logic [3:0] r, g, b;
  } exp_t;

  exp_t        sb[$];
  int          checks = 0;
  int          failures = 0;
  int          px_m, py_m, base_m;
  bit          flip_m;
  logic [15:0] addr_m;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Apply one pixel and push its expected S3 result from the reference model.
  task automatic drive(input int x, input int y, input bit bl, input bit fs);
    int   rx, ry, col;
    bit   hit;
    logic [2:0] idx;
    exp_t e;
    reset = 1'b0; draw_x = 10'(x); draw_y = 10'(y); blank = bl; frame_start = fs;
    rx  = x - px_m;
    ry  = y - py_m;
    hit = (x >= px_m) && (rx < W) && (y >= py_m) && (ry < H);
    e   = '{1'b0, 4'd0, 4'd0, 4'd0};
    if (hit) begin
      col    = flip_m ? (W - 1 - rx) : rx;
      addr_m = 16'((base_m + ry * W + col) % 65536);
      idx    = rom_f(addr_m);
      if (bl && idx != 3'd0) e = '{1'b1, {1'b0, idx}, {1'b0, idx} + 4'd3, ~{1'b0, idx}};
    end
    sb.push_back(e);
    if (fs) begin
      px_m   = int'(pos_x);
      py_m   = int'(pos_y);
      base_m = (int'(frame_sel) >= NFRAMES) ? 0 : int'(frame_sel) * W * H;
`ifdef SPRITE_HFLIP_EN
      flip_m = flip;
`endif
    end
  endtask

  // Reset cycle: everything in flight is flushed and latched state returns to 0.
  task automatic rst_drive(input int x, input int y);
    reset = 1'b1; draw_x = 10'(x); draw_y = 10'(y); blank = 1'b1; frame_start = 1'b0;
    foreach (sb[i]) sb[i] = '{1'b0, 4'd0, 4'd0, 4'd0};
    sb.push_back('{1'b0, 4'd0, 4'd0, 4'd0});
    px_m = 0; py_m = 0; base_m = 0; flip_m = 1'b0; addr_m = 16'd0;
  endtask

  task automatic cycle();
    exp_t e;
    @(negedge vga_clk);
    if (sb.size() >= 3) begin
      e = sb.pop_front();
      check("opaque", 32'(opaque), 32'(e.opq));
      check("red",    32'(red),    32'(e.r));
      check("green",  32'(green),  32'(e.g));
      check("blue",   32'(blue),   32'(e.b));
    end
    check("rom_address", 32'(rom_address), 32'(addr_m));
  endtask

  task automatic px(input int x, input int y, input bit bl);
    drive(x, y, bl, 1'b0);
    cycle();
  endtask

  initial begin
    pos_x = 10'd100; pos_y = 10'd50; frame_sel = 2'd0; flip = 1'b0;
    draw_x = '0; draw_y = '0; blank = 1'b0; frame_start = 1'b0; reset = 1'b1;
    px_m = 0; py_m = 0; base_m = 0; flip_m = 1'b0; addr_m = 16'd0;
    sb.push_back('{1'b0, 4'd0, 4'd0, 4'd0});
    sb.push_back('{1'b0, 4'd0, 4'd0, 4'd0});

    // Reset held two clocks while drawing inside the sprite at its reset position.
    rst_drive(20, 20); cycle();
    rst_drive(20, 20); cycle();
    check("rst_opaque", 32'(opaque), 32'd0);
    check("rst_addr", 32'(rom_address), 32'd0);

    // Latch pos (100,50) frame 0; this pixel still uses the reset placement.
    drive(20, 20, 1'b1, 1'b1); cycle();
    px(100, 50, 1'b1);
    check("addr_origin", 32'(rom_address), 32'd0);
    px(0, 0, 1'b0);
    px(0, 0, 1'b0);
    check("origin_opaque", 32'(opaque), 32'd1);
    check("origin_red", 32'(red), 32'd5);

    px(195, 50, 1'b1);
    check("addr_right_edge", 32'(rom_address), 32'd95);
    px(196, 50, 1'b1);
    px(100, 161, 1'b1);
    check("addr_bottom_edge", 32'(rom_address), 32'd10656);
    px(100, 162, 1'b1);
    px(99, 50, 1'b1);
    px(100, 49, 1'b1);
    px(103, 50, 1'b1);
    px(101, 50, 1'b0);
    px(0, 0, 1'b0);
    px(0, 0, 1'b0);
    check("blank_opaque", 32'(opaque), 32'd0);

    // Mid-frame position change without frame_start is ignored.
    pos_x = 10'd300;
    px(100, 50, 1'b1);
    check("addr_no_relatch", 32'(rom_address), 32'd0);

    // Frame 2: the pixel coincident with frame_start uses the old base.
    pos_x = 10'd100; frame_sel = 2'd2;
    drive(100, 50, 1'b1, 1'b1); cycle();
    check("addr_fs_old", 32'(rom_address), 32'd0);
    px(100, 50, 1'b1);
    check("addr_frame2", 32'(rom_address), 32'd21504);
    px(195, 161, 1'b1);

    // Out-of-range frame latches as frame 0.
    frame_sel = 2'd3;
    drive(0, 0, 1'b0, 1'b1); cycle();
    px(101, 50, 1'b1);
    check("addr_bad_frame", 32'(rom_address), 32'd1);

    // Sprite hanging off the right edge: clipped, no wrap to column 0.
    pos_x = 10'd1000; frame_sel = 2'd1;
    drive(0, 0, 1'b0, 1'b1); cycle();
    px(1023, 50, 1'b1);
    check("addr_clip", 32'(rom_address), 32'(10752 + 23));
    px(0, 50, 1'b1);
    px(5, 51, 1'b1);

    // Randomised burst around the sprite at (120,60), frame 1.
    pos_x = 10'd120; pos_y = 10'd60;
    drive(0, 0, 1'b0, 1'b1); cycle();
    for (int i = 0; i < 60; i++)
      px(int'($urandom_range(110, 225)), int'($urandom_range(50, 180)), 1'($urandom_range(0, 3) != 0));

    // Reset mid-line flushes the pipeline.
    px(120, 60, 1'b1);
    px(121, 60, 1'b1);
    rst_drive(130, 70); cycle();
    px(10, 10, 1'b1);
    px(11, 10, 1'b1);
    px(12, 10, 1'b1);

`ifdef SPRITE_HFLIP_EN
    pos_x = 10'd100; pos_y = 10'd50; frame_sel = 2'd0; flip = 1'b1;
    drive(0, 0, 1'b0, 1'b1); cycle();
    px(100, 50, 1'b1);
    check("flip_left", 32'(rom_address), 32'd95);
    px(195, 50, 1'b1);
    check("flip_right", 32'(rom_address), 32'd0);
    for (int i = 0; i < 20; i++)
      px(int'($urandom_range(95, 200)), int'($urandom_range(45, 165)), 1'b1);
`endif

    for (int i = 0; i < 3; i++) px(0, 0, 1'b0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
